// File: rtl/grom_bus_pkg.sv
// Shared GROM bus encodings, FSM states and command latch layout.
// Pure declarations: no latency, no flow control.
package grom_bus_pkg;

    localparam int GROM_ADDR_W = 13;
    localparam int GROM_ID_W   = 3;

    typedef enum logic [1:0] {
        GROM_OP_SET_ADDR   = 2'b00,
        GROM_OP_READ_DATA  = 2'b01,
        GROM_OP_READ_ADDR  = 2'b10,
        GROM_OP_WRITE_DATA = 2'b11
    } grom_op_e;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'b00,
        ST_ISSUE   = 2'b01,
        ST_CAPTURE = 2'b10,
        ST_DONE    = 2'b11
    } grom_state_e;

    typedef struct packed {
        grom_op_e               op;
        logic [GROM_ID_W-1:0]   id;
        logic [GROM_ADDR_W-1:0] addr;
    } grom_cmd_t;

    // Strobes a command needs; an unsynced SET_ADDR carries one extra dummy read.
    function automatic logic [8:0] strobe_total(input grom_op_e op,
                                                input logic [7:0] count,
                                                input logic synced);
        case (op)
            GROM_OP_SET_ADDR:  strobe_total = synced ? 9'd2 : 9'd3;
            GROM_OP_READ_DATA: strobe_total = {1'b0, count} + 9'd1;
            GROM_OP_READ_ADDR: strobe_total = 9'd2;
            default:           strobe_total = 9'd1;
        endcase
    endfunction

endpackage

// File: rtl/grom_host_if.sv
// Command/response handshake plus the GROM port pins of the bus initiator.
// Wires only: no latency; cmd_ready gates command acceptance.
interface grom_host_if;

    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [15:0] cmd_addr;
    logic [7:0]  cmd_wdata;
    logic [7:0]  cmd_count;
    logic        rsp_valid;
    logic [7:0]  rsp_data;
    logic        rsp_last;
    logic        busy;
    logic        gs;
    logic        m;
    logic        mo;
    logic [7:0]  d;
    logic [7:0]  q;
    logic        gready;

    modport slave (
        input  cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_count, q, gready,
        output cmd_ready, rsp_valid, rsp_data, rsp_last, busy, gs, m, mo, d
    );

    modport master (
        output cmd_valid, cmd_op, cmd_addr, cmd_wdata, cmd_count, q, gready,
        input  cmd_ready, rsp_valid, rsp_data, rsp_last, busy, gs, m, mo, d
    );

endinterface

// File: rtl/grom_strobe.sv
// Strobe timing: gs fires in the request cycle that sees grclk_en and gready; cap follows one cycle later.
// gready low holds the request indefinitely with gs at 0.
module grom_strobe
    import grom_bus_pkg::*;
(
    input  logic clk,
    input  logic reset,
    input  logic req,
    input  logic grclk_en,
    input  logic gready,
    output logic gs,
    output logic cap
);

    // Gated by reset so an aborted command never strobes in the reset cycle.
    assign gs = req && grclk_en && gready && !reset;

    always_ff @(posedge clk) begin
        if (reset) begin
            cap <= 1'b0;
        end else begin
            cap <= gs;
        end
    end

endmodule

// File: rtl/grom_host.sv
// GROM bus initiator: byte commands in, GROM strobes out, read bytes back as rsp pulses 2 cycles after each strobe.
// One command at a time: cmd_ready only in IDLE; strobes wait on grclk_en and gready.
module grom_host
    import grom_bus_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        grclk_en,
    grom_host_if.slave  bus
);

    grom_state_e state;
    grom_cmd_t   cmd;
    grom_op_e    op_in;
    logic [8:0]  left;
    logic        dummy;
    logic        synced;
    logic        m_q;
    logic        mo_q;
    logic [7:0]  d_q;
    logic        rsp_valid_q;
    logic        rsp_last_q;
    logic [7:0]  rsp_data_q;
    logic        issue;
    logic        gs;
    logic        cap;

    assign op_in = grom_op_e'(bus.cmd_op);
    assign issue = (state == ST_ISSUE);

    grom_strobe u_strobe (
        .clk      (clk),
        .reset    (reset),
        .req      (issue),
        .grclk_en (grclk_en),
        .gready   (bus.gready),
        .gs       (gs),
        .cap      (cap)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= ST_IDLE;
            cmd         <= '0;
            left        <= '0;
            dummy       <= 1'b0;
            synced      <= 1'b0;
            m_q         <= 1'b1;
            mo_q        <= 1'b0;
            d_q         <= 8'h00;
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            rsp_data_q  <= 8'h00;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_last_q  <= 1'b0;
            if (gs && m_q) begin
                synced <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    if (bus.cmd_valid) begin
                        cmd.op   <= op_in;
                        cmd.id   <= bus.cmd_addr[15:13];
                        cmd.addr <= bus.cmd_addr[12:0];
                        left     <= strobe_total(op_in, bus.cmd_count, synced);
                        dummy    <= (op_in == GROM_OP_SET_ADDR) && !synced;
                        state    <= ST_ISSUE;
                        case (op_in)
                            GROM_OP_SET_ADDR: begin
                                // A data read first clears the responder's address-byte toggle.
                                if (!synced) begin
                                    m_q  <= 1'b1;
                                    mo_q <= 1'b0;
                                    d_q  <= 8'h00;
                                end else begin
                                    m_q  <= 1'b0;
                                    mo_q <= 1'b1;
                                    d_q  <= bus.cmd_addr[15:8];
                                end
                            end
                            GROM_OP_READ_DATA: begin
                                m_q  <= 1'b1;
                                mo_q <= 1'b0;
                            end
                            GROM_OP_READ_ADDR: begin
                                m_q  <= 1'b1;
                                mo_q <= 1'b1;
                            end
                            default: begin
                                m_q  <= 1'b0;
                                mo_q <= 1'b0;
                                d_q  <= bus.cmd_wdata;
                            end
                        endcase
                    end
                end
                ST_ISSUE: begin
                    if (gs) begin
                        state <= ST_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    if (m_q && !dummy) begin
                        rsp_valid_q <= 1'b1;
                        rsp_data_q  <= bus.q;
                        rsp_last_q  <= (left == 9'd1);
                    end
                    if (left == 9'd1) begin
                        state <= ST_DONE;
                    end else begin
                        left  <= left - 9'd1;
                        state <= ST_ISSUE;
                        // Only SET_ADDR changes pin values between strobes: dummy -> high -> low.
                        if (cmd.op == GROM_OP_SET_ADDR) begin
                            m_q   <= 1'b0;
                            mo_q  <= 1'b1;
                            d_q   <= dummy ? {cmd.id, cmd.addr[12:8]} : cmd.addr[7:0];
                            dummy <= 1'b0;
                        end
                    end
                end
                ST_DONE: begin
                    state <= ST_IDLE;
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.cmd_ready = (state == ST_IDLE);
    assign bus.busy      = (state != ST_IDLE);
    assign bus.gs        = gs;
    assign bus.m         = m_q;
    assign bus.mo        = mo_q;
    assign bus.d         = d_q;
    assign bus.rsp_valid = rsp_valid_q;
    assign bus.rsp_data  = rsp_data_q;
    assign bus.rsp_last  = rsp_last_q;

endmodule

// File: tb/tb_grom_host.sv
// Directed bench for grom_host with a small GROM responder model and strobe/response logs.
module tb_grom_host;
    import grom_bus_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic grclk_en;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_err = 0;

    grom_host_if bus();

    grom_host dut (
        .clk      (clk),
        .reset    (reset),
        .grclk_en (grclk_en),
        .bus      (bus)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    // GROM clock enable is high in every cycle whose number is 3 mod 4.
    assign grclk_en = (cyc[1:0] == 2'b11);

    // Responder: registered q, address written high byte first, address read returns address+1.
    logic [15:0] gaddr = 16'h0000;
    logic        flip = 1'b1;
    logic [15:0] ap1;
    assign ap1 = gaddr + 16'd1;

    function automatic logic [7:0] rom(input logic [15:0] a);
        case (a)
            16'h6000: rom = 8'hAA;
            16'h6001: rom = 8'h55;
            16'h6002: rom = 8'h12;
            default:  rom = a[7:0] ^ 8'h3C;
        endcase
    endfunction

    always @(posedge clk) begin
        if (bus.gs) begin
            if (!bus.mo) begin
                flip  <= 1'b0;
                gaddr <= gaddr + 16'd1;
                if (bus.m) bus.q <= rom(gaddr);
            end else if (!bus.m) begin
                gaddr <= {gaddr[7:0], bus.d};
                flip  <= ~flip;
            end else begin
                bus.q <= flip ? ap1[7:0] : ap1[15:8];
                flip  <= ~flip;
            end
        end
    end

    logic [9:0] st_log[$];
    int         st_cyc[$];
    logic [8:0] rsp_log[$];

    always @(posedge clk) begin
        if (bus.gs) begin
            st_log.push_back({bus.mo, bus.m, bus.d});
            st_cyc.push_back(cyc);
        end
        if (bus.rsp_valid) rsp_log.push_back({bus.rsp_last, bus.rsp_data});
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    function automatic int next_en(input int c);
        return c + ((7 - (c % 4)) % 4);
    endfunction

    // Called at a negedge with cmd_ready high; returns one negedge after acceptance.
    task automatic send(input grom_op_e op, input logic [15:0] addr, input logic [7:0] wd,
                        input logic [7:0] cnt, output int t_acc);
        bus.cmd_valid = 1'b1;
        bus.cmd_op    = op;
        bus.cmd_addr  = addr;
        bus.cmd_wdata = wd;
        bus.cmd_count = cnt;
        t_acc = cyc;
        @(negedge clk);
        bus.cmd_valid = 1'b0;
        bus.cmd_addr  = 16'hFFFF;
        bus.cmd_wdata = 8'hFF;
        bus.cmd_count = 8'h00;
    endtask

    task automatic wait_idle(input string tag, output int t_rdy);
        int n = 0;
        while (bus.cmd_ready !== 1'b1 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        t_rdy = cyc;
        chk(tag, bus.cmd_ready, 1);
    endtask

    initial begin
        int ta, tr, sb, rb, k, nl, st_snap, rsp_snap;
        bus.cmd_valid = 1'b0;
        bus.cmd_op    = 2'b00;
        bus.cmd_addr  = 16'h0000;
        bus.cmd_wdata = 8'h00;
        bus.cmd_count = 8'h00;
        bus.gready    = 1'b1;

        repeat (3) @(negedge clk);
        reset = 1'b0;
        chk("rst_cmd_ready", bus.cmd_ready, 1);
        chk("rst_busy", bus.busy, 0);
        chk("rst_gs", bus.gs, 0);
        chk("rst_m", bus.m, 1);
        chk("rst_mo", bus.mo, 0);
        chk("rst_d", bus.d, 8'h00);
        chk("rst_rsp_valid", bus.rsp_valid, 0);
        chk("rst_rsp_data", bus.rsp_data, 8'h00);
        chk("rst_rsp_last", bus.rsp_last, 0);

        // First SET_ADDR after reset: dummy read, then high and low address bytes.
        sb = st_log.size(); rb = rsp_log.size();
        send(GROM_OP_SET_ADDR, 16'h6000, 8'h00, 8'h00, ta);
        wait_idle("sa1_done", tr);
        chk("sa1_nstrobe", st_log.size() - sb, 3);
        chk("sa1_dummy_mo_m", st_log[sb][9:8], 2'b01);
        chk("sa1_hi", st_log[sb+1], {2'b10, 8'h60});
        chk("sa1_lo", st_log[sb+2], {2'b10, 8'h00});
        chk("sa1_spacing", st_cyc[sb+1] - st_cyc[sb], 4);
        chk("sa1_no_rsp", rsp_log.size() - rb, 0);

        sb = st_log.size();
        send(GROM_OP_SET_ADDR, 16'h6000, 8'h00, 8'h00, ta);
        wait_idle("sa2_done", tr);
        chk("sa2_nstrobe", st_log.size() - sb, 2);
        chk("sa2_hi", st_log[sb], {2'b10, 8'h60});
        chk("sa2_lo", st_log[sb+1], {2'b10, 8'h00});

        // Three-byte data read.
        sb = st_log.size(); rb = rsp_log.size();
        send(GROM_OP_READ_DATA, 16'h0000, 8'h00, 8'd2, ta);
        wait_idle("rd3_done", tr);
        chk("rd3_nstrobe", st_log.size() - sb, 3);
        chk("rd3_mo_m", st_log[sb+2][9:8], 2'b01);
        chk("rd3_nrsp", rsp_log.size() - rb, 3);
        chk("rd3_b0", rsp_log[rb], {1'b0, 8'hAA});
        chk("rd3_b1", rsp_log[rb+1], {1'b0, 8'h55});
        chk("rd3_b2", rsp_log[rb+2], {1'b1, 8'h12});

        // Single-byte read latency, then address readback.
        send(GROM_OP_SET_ADDR, 16'h6000, 8'h00, 8'h00, ta);
        wait_idle("sa3_done", tr);
        rb = rsp_log.size();
        send(GROM_OP_READ_DATA, 16'h0000, 8'h00, 8'd0, ta);
        wait_idle("rd1_done", tr);
        chk("rd1_latency", tr - ta, next_en(ta + 1) + 3 - ta);
        chk("rd1_le7", (tr - ta) <= 7, 1);
        chk("rd1_rsp", rsp_log[rb], {1'b1, 8'hAA});

        sb = st_log.size(); rb = rsp_log.size();
        send(GROM_OP_READ_ADDR, 16'h0000, 8'h00, 8'h00, ta);
        wait_idle("ra_done", tr);
        chk("ra_nstrobe", st_log.size() - sb, 2);
        chk("ra_mo_m", st_log[sb][9:8], 2'b11);
        chk("ra_hi", rsp_log[rb], {1'b0, 8'h60});
        chk("ra_lo", rsp_log[rb+1], {1'b1, 8'h02});

        // gready stall.
        bus.gready = 1'b0;
        sb = st_log.size(); rb = rsp_log.size();
        send(GROM_OP_READ_DATA, 16'h0000, 8'h00, 8'd0, ta);
        repeat (50) @(negedge clk);
        chk("stall_no_gs", st_log.size() - sb, 0);
        chk("stall_busy", bus.busy, 1);
        chk("stall_cmd_ready", bus.cmd_ready, 0);
        k = cyc;
        bus.gready = 1'b1;
        wait_idle("stall_done", tr);
        chk("stall_first_strobe", st_cyc[sb], next_en(k));
        chk("stall_rsp", rsp_log[rb], {1'b1, 8'h55});

        // Single write.
        sb = st_log.size(); rb = rsp_log.size();
        send(GROM_OP_WRITE_DATA, 16'h0000, 8'h5A, 8'h00, ta);
        wait_idle("wr_done", tr);
        chk("wr_nstrobe", st_log.size() - sb, 1);
        chk("wr_strobe", st_log[sb], {2'b00, 8'h5A});
        chk("wr_no_rsp", rsp_log.size() - rb, 0);

        // Full 256-byte read.
        sb = st_log.size(); rb = rsp_log.size();
        send(GROM_OP_READ_DATA, 16'h0000, 8'h00, 8'd255, ta);
        wait_idle("rd256_done", tr);
        chk("rd256_nstrobe", st_log.size() - sb, 256);
        chk("rd256_nrsp", rsp_log.size() - rb, 256);
        nl = 0;
        for (int i = rb; i < rsp_log.size(); i++) if (rsp_log[i][8]) nl++;
        chk("rd256_nlast", nl, 1);
        chk("rd256_final_last", rsp_log[rsp_log.size()-1][8], 1);

        // Reset in a grclk_en cycle in the middle of a long read.
        rb = rsp_log.size();
        send(GROM_OP_READ_DATA, 16'h0000, 8'h00, 8'd255, ta);
        repeat (60) @(negedge clk);
        while (cyc % 4 != 3) @(negedge clk);
        reset = 1'b1;
        st_snap = st_log.size();
        #1;
        chk("rst_mid_gs", bus.gs, 0);
        @(negedge clk);
        reset = 1'b0;
        rsp_snap = rsp_log.size();
        chk("rst_mid_progress", (rsp_snap - rb) > 5, 1);
        chk("rst_mid_ready", bus.cmd_ready, 1);
        chk("rst_mid_busy", bus.busy, 0);
        @(negedge clk);
        chk("rst_mid_ready2", bus.cmd_ready, 1);
        repeat (20) @(negedge clk);
        chk("rst_mid_no_gs", st_log.size() - st_snap, 0);
        chk("rst_mid_no_rsp", rsp_log.size() - rsp_snap, 0);

        // Reset cleared the sync flag, so the dummy read returns.
        sb = st_log.size();
        send(GROM_OP_SET_ADDR, 16'h6000, 8'h00, 8'h00, ta);
        wait_idle("sa4_done", tr);
        chk("sa4_nstrobe", st_log.size() - sb, 3);
        chk("sa4_dummy_mo_m", st_log[sb][9:8], 2'b01);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/grom_host.md
# grom_host

GROM bus initiator: turns byte-level commands from a system-side controller into correctly timed GROM port strobes (gs/m/mo/d), sampling q and honouring gready. It drives the same bus the console GROM set responds on, so a soft CPU, DMA engine or loader can set and read back GROM addresses, stream GROM data and write GRAM. Each strobe is aligned to the ~447 kHz GROM clock enable.

## Interface
- No parameters.
- clk  in  1  system clock; single clock domain.
- reset  in  1  synchronous, active-high.
- grclk_en  in  1  GROM clock enable, a one-cycle pulse every ≥2 clk.
- cmd_valid  in  1  command request.
- cmd_ready  out  1  high in IDLE; a command is accepted on cmd_valid && cmd_ready.
- cmd_op  in  2  00 SET_ADDR, 01 READ_DATA, 10 READ_ADDR, 11 WRITE_DATA.
- cmd_addr  in  16  address for SET_ADDR, sent as {grom_id[0:2], addr[0:12]}.
- cmd_wdata  in  8  byte for WRITE_DATA.
- cmd_count  in  8  READ_DATA byte count minus 1 (0 = 1 byte, 255 = 256 bytes); ignored for other ops.
- rsp_valid  out  1  one-cycle pulse per byte read.
- rsp_data  out  8  byte read.
- rsp_last  out  1  qualifies the final rsp_valid of a command.
- busy  out  1  high when not in IDLE.
- gs  out  1  GROM select strobe.
- m  out  1  1 = read, 0 = write.
- mo  out  1  1 = address port, 0 = data port.
- d  out  8  write data to the GROMs.
- q  in  8  read data from the GROMs, registered by the responder on the strobe edge.
- gready  in  1  responder ready.

## Operation
- States:
  - IDLE → ISSUE on accept.
  - ISSUE: wait for a strobe cycle → CAPTURE.
  - CAPTURE: one cycle → ISSUE if strobes remain, else DONE.
  - DONE: one cycle → IDLE.
- Strobe cycle: a cycle in ISSUE with grclk_en=1 and gready=1.
  - gs=1 in exactly that cycle, otherwise 0.
  - m, mo and d are registered, and stable from ISSUE entry through CAPTURE.
- Strobe sequences per op:
  - SET_ADDR: two strobes with mo=1, m=0; d = cmd_addr[0:7], then cmd_addr[8:15].
  - READ_DATA: cmd_count+1 strobes with mo=0, m=1; one response each.
  - READ_ADDR: two strobes with mo=1, m=1; responses are the high byte, then the low byte.
  - WRITE_DATA: one strobe with mo=0, m=0, d = cmd_wdata; no response.
- Byte-pointer resync: a `synced` flag clears on reset and sets after any read strobe.
  - If `synced`=0, SET_ADDR first issues one dummy data read (mo=0, m=1) and discards it.
  - This clears the responder's address-byte toggle.
- In CAPTURE of a read strobe, q is latched into rsp_data.
  - rsp_valid is asserted the following cycle.
  - rsp_last=1 on the final byte.
- The command is latched on accept; cmd_* may change afterwards.
- Remaining-count arithmetic is 9-bit internally, so count 255 yields exactly 256 strobes with no wrap.

## Timing
- Reset values: state IDLE, cmd_ready=1, busy=0, gs=0, m=1, mo=0, d=0x00, rsp_valid=0, rsp_data=0x00, rsp_last=0, synced=0.
- Reset has priority in every state. A reset mid-command aborts the command: no gs in the reset cycle, no further rsp.
- Accept at cycle T → ISSUE from T+1. The earliest strobe is at T+1 if grclk_en and gready are both high.
- Strobe at cycle S: q is sampled at S+1 (CAPTURE), rsp_valid at S+2.
- Consecutive strobes are at least one grclk_en period apart. A strobe cannot coincide with CAPTURE.
- gready=0 stalls ISSUE indefinitely with no timeout; gs stays 0.
- Command latency from accept to cmd_ready high again:
  - READ_DATA count 0 with grclk_en every 4 clk and gready=1: ≤ 4+3 cycles.
  - Ends with the DONE cycle followed by IDLE.
- cmd_valid in a non-IDLE cycle is ignored (cmd_ready=0).

## Structure
- Package grom_bus_pkg:
  - op encodings GROM_OP_SET_ADDR/READ_DATA/READ_ADDR/WRITE_DATA;
  - state enum;
  - GROM_ADDR_W=13, GROM_ID_W=3.
- One sub-module, grom_strobe: ISSUE/CAPTURE timing. It takes a request, grclk_en and gready, and outputs gs plus a capture pulse.
- The top level holds the command latch, count, sync flag and response registers.

## Test plan
- Reset, then SET_ADDR 0x6000 → dummy strobe (mo=0, m=1) with no rsp, then strobes d=0x60 and d=0x00 (mo=1, m=0). A second SET_ADDR has no dummy strobe.
- Responder model with bytes 0xAA, 0x55, 0x12 at 0x6000 → SET_ADDR 0x6000, READ_DATA count=2 → rsp 0xAA, 0x55, 0x12; rsp_last only on 0x12.
- After SET_ADDR 0x6000 and one data read → READ_ADDR returns 0x60 then 0x02.
- gready held low 50 cycles during READ_DATA → gs stays 0. First strobe comes on the first grclk_en after gready rises.
- WRITE_DATA 0x5A → a single strobe with mo=0, m=0, d=0x5A; rsp_valid never asserted.
- Reset asserted mid READ_DATA count=255 → gs=0 from the reset cycle, no further rsp_valid, and cmd_ready=1 the cycle after reset deasserts.
